gpio_p2s_ctrl: RTL and testbench
================================

# gpio_p2s_ctrl

Parametrised general-purpose output port with an integrated LED serialiser. It sits on the CPU I/O bus behind the address decoder. A write strobe splits one bus word into an auxiliary output field, an LED field and a counter-select field. Every LED update, and every explicit refresh request, is shifted out on a serial clock/data/latch link to an external shift-register LED chain. The block adds frame queuing, a busy/done handshake, configurable bit order and clock rate, and optional register readback.

## Interface
Parameters:
- LED_W, 16, LED field width and serial frame length in bits (2..32)
- CS_W, 2, counter-select field width
- AUX_W, 14, auxiliary output field width
- DIV, 2, serial clock half-period in clk cycles (>=1)
- MSB_FIRST, 1, 1: led[LED_W-1] shifted first; 0: led[0] first
- LED_RST, 16'h002A, LED field reset value (zero-extended or truncated to LED_W)

Ports (DW = AUX_W+LED_W+CS_W):
- clk  in  1  rising-edge clock for all state
- rst  in  1  reset, asynchronous, active-high
- en  in  1  write strobe, sampled on the rising clk edge
- wdata  in  DW  write word {aux, led, cs}, with cs in the LSBs
- start  in  1  refresh request: reshift the current LED value without a write
- aux_out  out  AUX_W  auxiliary output register
- led_out  out  LED_W  LED register (parallel mirror of the chain contents)
- counter_set  out  CS_W  counter-select register
- busy  out  1  serial frame in progress
- done  out  1  one-cycle pulse at frame end
- sclk  out  1  serial clock
- sout  out  1  serial data
- sclrn  out  1  chain clear, active-low
- pen  out  1  chain parallel latch enable, one-cycle pulse
- rdata  out  DW  readback of {aux_out, led_out, counter_set}

## Operation
- Register fields: when en=1, at the clock edge {aux_out, led_out, counter_set} <= wdata. When en=0, all three hold. Writes are accepted in every FSM state.
- Refresh request: a frame is requested by en=1 or start=1.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE to SHIFT: when a request is present.
  - snap <= LED value taken from wdata if en=1, otherwise from led_out.
  - bit counter <= 0, divide counter <= 0.
- SHIFT, per bit:
  - sout presents the current snap bit (MSB or LSB per MSB_FIRST).
  - sclk is low for DIV cycles, then high for DIV cycles.
  - snap shifts and the bit counter increments when the high phase ends.
  - After bit LED_W-1, go to LATCH.
- LATCH: one cycle. pen=1, done=1, sclk=0.
  - If pending=1 or a request is present: go to SHIFT with a fresh snapshot (same rule as IDLE) and clear pending.
  - Otherwise go to IDLE.
- Pending flag: set by any request arriving in SHIFT. It collapses to a single queued frame and never holds more than one. The queued frame always carries the newest led_out.
- busy = (state != IDLE).
- sclrn: registered, reset value 0, becomes 1 on the first clk edge after rst deasserts.
- Width rules: wdata bit slicing is fixed. LED_RST is zero-extended or truncated to LED_W.

## Timing
- Reset values: aux_out=0, led_out=LED_RST, counter_set=0, busy=0, done=0, sclk=0, sout=0, pen=0, sclrn=0, pending=0, state=IDLE.
- Register latency: wdata appears on the outputs at the edge that samples en, so it is visible in the next cycle.
- Request accepted at edge k:
  - busy=1 from k+1.
  - First sclk rise after DIV cycles.
  - pen/done high in cycle k+1+2·DIV·LED_W.
  - With defaults, pen is high 64 cycles after k+1, and busy lasts 65 cycles.
- Back-to-back frames: when pending, busy does not drop between frames, and the next frame's first bit follows the LATCH cycle immediately.
- sout changes only while sclk=0, and is stable for the full sclk-high phase.
- Simultaneous en and start: treated as one request, using the written LED value.
- Reset mid-frame: all state returns to reset values asynchronously. No pen pulse is issued for the aborted frame.

## Configuration
- GPIO_READBACK_EN:
  - Defined: rdata = {aux_out, led_out, counter_set}, combinational from the registers.
  - Undefined: rdata is tied to 0 and no readback mux is built.

## Test plan
- Reset: assert rst mid-simulation -> led_out=16'h002A, counter_set=0, aux_out=0, sclrn=0, busy=0. After release, sclrn=1 on the next edge.
- Write decode: en pulse with wdata=32'hABCD1235 -> counter_set=2'b01, led_out=16'h448D, aux_out=14'h2AF3. The serial capture (MSB_FIRST=1) of 16 bits on sclk rises reads 16'h448D. pen pulses once, exactly 65 cycles after the write edge.
- Queued write: write 16'h00FF (led field) and, at cycle 10 of that frame, write 16'hF00F, then write 16'h1234 at cycle 20 -> two frames total, back-to-back with no busy gap. The second frame captures 16'h1234, and there are exactly two pen pulses.
- Start refresh: start=1 while IDLE with led_out=16'h002A -> one frame capturing 16'h002A, with registers unchanged.
- Reset mid-frame: rst asserted at frame cycle 30 -> sclk=sout=pen=busy=0 immediately, no pen pulse, and no frame starts after release until a new request.
- Readback and order: with GPIO_READBACK_EN, rdata equals the last wdata. Without it, rdata=0. With MSB_FIRST=0, a capture of led 16'h0001 shows the first bit =1.

Source files
------------

// File: rtl/gpio_p2s_ctrl.sv
// gpio_p2s_ctrl: bus-written GPIO output register with a serial LED-chain shifter.
// Each LED write or refresh request shifts the LED field out on sclk/sout and
// then latches the chain with a pen pulse. Requests that arrive mid-frame
// collapse into one queued frame.
// Optional feature macro: GPIO_READBACK_EN (drives rdata from the registers).
module gpio_p2s_ctrl #(
  parameter int unsigned LED_W     = 16,
  parameter int unsigned CS_W      = 2,
  parameter int unsigned AUX_W     = 14,
  parameter int unsigned DIV       = 2,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic [31:0] LED_RST   = 32'h0000_002A
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [AUX_W+LED_W+CS_W-1:0]   wdata,
  input  logic                          start,
  output logic [AUX_W-1:0]              aux_out,
  output logic [LED_W-1:0]              led_out,
  output logic [CS_W-1:0]               counter_set,
  output logic                          busy,
  output logic                          done,
  output logic                          sclk,
  output logic                          sout,
  output logic                          sclrn,
  output logic                          pen,
  output logic [AUX_W+LED_W+CS_W-1:0]   rdata
);

  localparam int unsigned DIV_CW = $clog2(2 * DIV);
  localparam int unsigned BIT_CW = $clog2(LED_W);
  localparam logic [LED_W-1:0] LED_RST_V = LED_W'(LED_RST);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_e;

  state_e              state_q, state_d;
  logic [AUX_W-1:0]    aux_q, aux_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic [CS_W-1:0]     cs_q, cs_d;
  logic [LED_W-1:0]    snap_q, snap_d;
  logic [BIT_CW-1:0]   bit_q, bit_d;
  logic [DIV_CW-1:0]   div_q, div_d;
  logic                pend_q, pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pen_q, pen_d;
  logic                sclk_q, sclk_d;
  logic                sout_q, sout_d;
  logic                sclrn_q;

  logic                req;
  logic                last_phase;
  logic [LED_W-1:0]    new_snap;
  logic [LED_W-1:0]    shifted;

  // Next-state, register decode and serial output computation
  always_comb begin
    state_d = state_q;
    aux_d   = aux_q;
    led_d   = led_q;
    cs_d    = cs_q;
    snap_d  = snap_q;
    bit_d   = bit_q;
    div_d   = div_q;
    pend_d  = pend_q;

    req        = en | start;
    new_snap   = en ? wdata[CS_W +: LED_W] : led_q;
    last_phase = (div_q == DIV_CW'(2 * DIV - 1));
    shifted    = MSB_FIRST ? {snap_q[LED_W-2:0], 1'b0} : {1'b0, snap_q[LED_W-1:1]};

    if (en) begin
      cs_d  = wdata[CS_W-1:0];
      led_d = wdata[CS_W +: LED_W];
      aux_d = wdata[CS_W+LED_W +: AUX_W];
    end

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_SHIFT;
          snap_d  = new_snap;
          bit_d   = '0;
          div_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (req) pend_d = 1'b1;
        if (last_phase) begin
          div_d  = '0;
          snap_d = shifted;
          bit_d  = bit_q + BIT_CW'(1);
          if (bit_q == BIT_CW'(LED_W - 1)) state_d = ST_LATCH;
        end else begin
          div_d = div_q + DIV_CW'(1);
        end
      end
      ST_LATCH: begin
        if (pend_q || req) begin
          state_d = ST_SHIFT;
          snap_d  = new_snap;
          bit_d   = '0;
          div_d   = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    pen_d  = (state_d == ST_LATCH);
    done_d = (state_d == ST_LATCH);
    sclk_d = (state_d == ST_SHIFT) && (div_d >= DIV_CW'(DIV));
    sout_d = (state_d == ST_SHIFT) && (MSB_FIRST ? snap_d[LED_W-1] : snap_d[0]);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      aux_q   <= '0;
      led_q   <= LED_RST_V;
      cs_q    <= '0;
      snap_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pen_q   <= 1'b0;
      sclk_q  <= 1'b0;
      sout_q  <= 1'b0;
      sclrn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      aux_q   <= aux_d;
      led_q   <= led_d;
      cs_q    <= cs_d;
      snap_q  <= snap_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pen_q   <= pen_d;
      sclk_q  <= sclk_d;
      sout_q  <= sout_d;
      sclrn_q <= 1'b1;
    end
  end

  assign aux_out     = aux_q;
  assign led_out     = led_q;
  assign counter_set = cs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pen         = pen_q;
  assign sclk        = sclk_q;
  assign sout        = sout_q;
  assign sclrn       = sclrn_q;

`ifdef GPIO_READBACK_EN
  assign rdata = {aux_q, led_q, cs_q};
`else
  assign rdata = '0;
`endif

endmodule

// File: tb/tb_gpio_p2s_ctrl.sv
// Testbench for gpio_p2s_ctrl: directed scenarios plus random traffic, checked
// every cycle against a frame-level reference model. A second instance with
// LSB-first order shares the stimulus and is checked on captured frames.
module tb_gpio_p2s_ctrl;

  localparam int unsigned L   = 16;
  localparam int unsigned CSW = 2;
  localparam int unsigned AW  = 14;
  localparam int unsigned D   = 2;
  localparam int unsigned DW  = AW + L + CSW;
  localparam int unsigned F   = 2 * D * L;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] wdata = '0;

  logic [AW-1:0]  aux_out, l_aux_out;
  logic [L-1:0]   led_out, l_led_out;
  logic [CSW-1:0] counter_set, l_counter_set;
  logic           busy, done, sclk, sout, sclrn, pen;
  logic           l_busy, l_done, l_sclk, l_sout, l_sclrn, l_pen;
  logic [DW-1:0]  rdata, l_rdata;

  gpio_p2s_ctrl u_dut (
    .clk(clk), .rst(rst), .en(en), .wdata(wdata), .start(start),
    .aux_out(aux_out), .led_out(led_out), .counter_set(counter_set),
    .busy(busy), .done(done), .sclk(sclk), .sout(sout), .sclrn(sclrn),
    .pen(pen), .rdata(rdata)
  );

  gpio_p2s_ctrl #(.MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .en(en), .wdata(wdata), .start(start),
    .aux_out(l_aux_out), .led_out(l_led_out), .counter_set(l_counter_set),
    .busy(l_busy), .done(l_done), .sclk(l_sclk), .sout(l_sout), .sclrn(l_sclrn),
    .pen(l_pen), .rdata(l_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference model
  int          cyc = 0;
  logic [AW-1:0]  m_aux;
  logic [L-1:0]   m_led;
  logic [CSW-1:0] m_cs;
  logic        m_active, m_pend, m_sclrn;
  int          m_start;
  logic [L-1:0]   m_snap;

  // Serial capture state
  logic [L-1:0] cap_m, cap_l;
  int           nb_m, nb_l;
  logic         prev_sclk, prev_lsclk;
  logic         first_l;
  int           pen_seen = 0;

  task automatic model_reset();
    m_aux = '0; m_led = L'(32'h002A); m_cs = '0;
    m_active = 1'b0; m_pend = 1'b0; m_sclrn = 1'b0;
    cap_m = '0; cap_l = '0; nb_m = 0; nb_l = 0;
    prev_sclk = 1'b0; prev_lsclk = 1'b0;
  endtask

  task automatic model_edge();
    logic req;
    cyc++;
    req = en | start;
    m_sclrn = 1'b1;
    if (en) begin
      m_cs  = wdata[CSW-1:0];
      m_led = wdata[CSW +: L];
      m_aux = wdata[CSW+L +: AW];
    end
    if (!m_active) begin
      if (req) begin m_active = 1'b1; m_start = cyc; m_snap = m_led; end
    end else if (cyc == m_start + F + 1) begin
      if (m_pend || req) begin m_start = cyc; m_snap = m_led; m_pend = 1'b0; end
      else m_active = 1'b0;
    end else if (req) begin
      m_pend = 1'b1;
    end
  endtask

  // Per-cycle comparison, sampled on the falling edge
  always @(negedge clk) begin
    int rel;
    int n;
    logic e_sclk, e_sout, e_pen;
    logic [DW-1:0] e_rdata;
    if (rst) model_reset(); else model_edge();
    rel    = cyc - m_start;
    e_pen  = m_active && (rel == F);
    e_sclk = m_active && (rel < F) && ((rel % (2 * D)) >= D);
    n      = rel / (2 * D);
    e_sout = m_active && (rel < F) && m_snap[L-1-n];
`ifdef GPIO_READBACK_EN
    e_rdata = {m_aux, m_led, m_cs};
`else
    e_rdata = '0;
`endif
    check("aux_out", 64'(aux_out), 64'(m_aux));
    check("led_out", 64'(led_out), 64'(m_led));
    check("counter_set", 64'(counter_set), 64'(m_cs));
    check("sclrn", 64'(sclrn), 64'(m_sclrn));
    check("busy", 64'(busy), 64'(m_active));
    check("pen", 64'(pen), 64'(e_pen));
    check("done", 64'(done), 64'(e_pen));
    check("sclk", 64'(sclk), 64'(e_sclk));
    check("sout", 64'(sout), 64'(e_sout));
    check("rdata", 64'(rdata), 64'(e_rdata));
    check("lsb_pen", 64'(l_pen), 64'(e_pen));
    if (pen) pen_seen++;
    if (!rst) begin
      if (sclk && !prev_sclk) begin cap_m = {cap_m[L-2:0], sout}; nb_m++; end
      if (l_sclk && !prev_lsclk) begin
        if (nb_l == 0) first_l = l_sout;
        cap_l = {l_sout, cap_l[L-1:1]};
        nb_l++;
      end
      prev_sclk = sclk;
      prev_lsclk = l_sclk;
      if (e_pen) begin
        check("frame_msb", 64'(cap_m), 64'(m_snap));
        check("frame_lsb", 64'(cap_l), 64'(m_snap));
        check("frame_bits", 64'(nb_m), 64'(L));
        cap_m = '0; cap_l = '0; nb_m = 0; nb_l = 0;
      end
    end
  end

  function automatic logic [DW-1:0] mk(input logic [AW-1:0] a, input logic [L-1:0] ld,
                                        input logic [CSW-1:0] c);
    return {a, ld, c};
  endfunction

  task automatic write(input logic [DW-1:0] w);
    @(negedge clk); #1; en = 1'b1; wdata = w;
    @(negedge clk); #1; en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 64'(busy), 64'(0));
    idle(3);
  endtask

  initial begin
    int p0;
    int r;
    idle(3);
    @(negedge clk); #1; rst = 1'b0;
    idle(4);

    // Write decode and first frame
    p0 = pen_seen;
    write(32'hABCD1235);
    check("dec_cs", 64'(counter_set), 64'(2'b01));
    check("dec_led", 64'(led_out), 64'(16'h448D));
    check("dec_aux", 64'(aux_out), 64'(14'h2AF3));
    wait_idle();
    check("dec_pens", 64'(pen_seen - p0), 64'(1));

    // Queued writes collapse into one back-to-back frame
    p0 = pen_seen;
    write(mk(14'h0, 16'h00FF, 2'b00));
    idle(8);
    write(mk(14'h1, 16'hF00F, 2'b10));
    idle(8);
    write(mk(14'h2, 16'h1234, 2'b11));
    wait_idle();
    check("queue_pens", 64'(pen_seen - p0), 64'(2));

    // Reset mid-frame
    p0 = pen_seen;
    write(mk(14'h3FFF, 16'hFFFF, 2'b11));
    idle(28);
    @(negedge clk); #1; rst = 1'b1;
    #1;
    check("rst_sclk", 64'(sclk), 64'(0));
    check("rst_sout", 64'(sout), 64'(0));
    check("rst_pen", 64'(pen), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_led", 64'(led_out), 64'(16'h002A));
    check("rst_sclrn", 64'(sclrn), 64'(0));
    idle(2);
    @(negedge clk); #1; rst = 1'b0;
    idle(20);
    check("rst_nopen", 64'(pen_seen - p0), 64'(0));

    // Start refresh of the reset LED value
    p0 = pen_seen;
    pulse_start();
    wait_idle();
    check("start_pens", 64'(pen_seen - p0), 64'(1));

    // LSB-first order: first shifted bit of led 0x0001
    write(mk(14'h0, 16'h0001, 2'b00));
    wait_idle();
    check("lsb_first_bit", 64'(first_l), 64'(1));

    // Simultaneous en and start use the written value
    @(negedge clk); #1; en = 1'b1; start = 1'b1; wdata = mk(14'h5, 16'hBEEF, 2'b01);
    @(negedge clk); #1; en = 1'b0; start = 1'b0;
    wait_idle();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      r = $urandom_range(0, 999);
      en    = (r < 50);
      start = (r >= 50 && r < 80);
      wdata = DW'($urandom);
      rst   = (r == 999) || (rst && $urandom_range(0, 1) == 0);
    end
    @(negedge clk); #1; en = 1'b0; start = 1'b0; rst = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
